// File: rtl/riscv.sv
// ---------------------------------------------------------------------------
// riscv -- single-cycle RV32I-subset core with private instruction memory,
// register file and data memory. Every instruction is fetched, decoded,
// executed and retired in one clock.
//
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous active-high reset (pc and x0..x31 cleared,
//         data memory contents retained, no write-back that cycle)
//
// Sub-modules (in this file):
//   riscv_imem : combinational-read program store, instance "insmem",
//                array "memfile" (loaded externally, read-only to the core)
//   riscv_dmem : word-wide data memory, instance "datamem", array "memfile"
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// riscv_imem -- instruction memory, combinational read.
// Ports:
//   word_addr : pc[31:2], reduced modulo WORDS internally
//   rdata     : instruction word at that location
// ---------------------------------------------------------------------------
module riscv_imem #(
    parameter int WORDS = 256
) (
    input  logic [29:0] word_addr,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] memfile [0:WORDS-1];
    logic [31:0] index;

    assign index = {2'b00, word_addr} % WORDS;
    assign rdata = memfile[AW'(index)];
endmodule

// ---------------------------------------------------------------------------
// riscv_dmem -- data memory, combinational read, synchronous write.
// Ports:
//   clk       : write clock
//   we        : write enable for this cycle
//   word_addr : byte address [31:2], reduced modulo WORDS internally
//   wdata     : word to store
//   rdata     : word currently stored at word_addr
// ---------------------------------------------------------------------------
module riscv_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [29:0] word_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] memfile [0:WORDS-1];
    logic [31:0] index;

    assign index = {2'b00, word_addr} % WORDS;
    assign rdata = memfile[AW'(index)];

    // Contents are deliberately not reset so programs can leave data behind.
    always_ff @(posedge clk) begin
        if (we) begin
            memfile[AW'(index)] <= wdata;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// riscv -- core top level.
// ---------------------------------------------------------------------------
module riscv #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [0:31];
    logic [31:0] regs_d [0:31];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] pc_plus4;
    logic [31:0] addr_sum;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;
    logic        rf_we;
    logic        mem_we;
    logic        br_taken;
    logic        legal;

    // ALU shared by OP and OP-IMM. 'alt' selects SUB over ADD and SRA over SRL.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'b0, $signed(a) < $signed(b)};
            3'b011:  r = {31'b0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    riscv_imem #(.WORDS(IMEM_WORDS)) insmem (
        .word_addr (pc_q[31:2]),
        .rdata     (instr)
    );

    // A store in the reset cycle is abandoned along with the rest of the instruction.
    riscv_dmem #(.WORDS(DMEM_WORDS)) datamem (
        .clk       (clk),
        .we        (mem_we && !rst),
        .word_addr (addr_sum[31:2]),
        .wdata     (rs2_val),
        .rdata     (mem_rdata)
    );

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    // One adder serves load/store addresses and the JALR target.
    assign addr_sum = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Decode/execute. Anything not recognised falls through as a NOP.
    always_comb begin
        pc_d    = pc_plus4;
        rf_we   = 1'b0;
        mem_we  = 1'b0;
        wb_data = 32'd0;
        legal   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                rf_we   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                rf_we   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OPC_JAL: begin
                rf_we   = 1'b1;
                wb_data = pc_plus4;
                pc_d    = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we   = 1'b1;
                    wb_data = pc_plus4;
                    pc_d    = addr_sum & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b010) begin
                    rf_we   = 1'b1;
                    wb_data = mem_rdata;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    mem_we = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // Only the shift forms constrain the upper immediate bits.
                case (funct3)
                    3'b001:  legal = (funct7 == 7'h00);
                    3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: legal = 1'b1;
                endcase
                if (legal) begin
                    rf_we   = 1'b1;
                    wb_data = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_val, imm_i);
                end
            end
            OPC_OP: begin
                legal = (funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                if (legal) begin
                    rf_we   = 1'b1;
                    wb_data = alu(funct3, instr[30], rs1_val, rs2_val);
                end
            end
            default: begin
                pc_d = pc_plus4;
            end
        endcase
    end

    // Register file next state; writes to x0 are dropped so it stays zero.
    always_comb begin
        regs_d = regs_q;
        if (rf_we && (rd != 5'd0)) begin
            regs_d[rd] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
        end
    end
endmodule

// File: tb/tb_riscv.sv
// ---------------------------------------------------------------------------
// tb_riscv -- directed programs for the riscv core with hand-computed
// expected register, memory and PC values.
// ---------------------------------------------------------------------------
module tb_riscv;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog [0:31];
    int          progLen;

    riscv #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] encI(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] encS(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] encB(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] encU(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] encJ(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] regsOr();
        logic [31:0] acc = 32'd0;
        for (int i = 0; i < 32; i++) acc |= dut.regs_q[i];
        return acc;
    endfunction

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Load prog[] (rest of memory = jal x0,0), apply one reset edge, check it, release.
    task automatic applyStimulus(input string name);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.insmem.memfile[i] = (i < progLen) ? prog[i] : 32'h0000006F;
        end
        @(negedge clk);
        checkOutput({name, "_rst_pc"}, dut.pc_q, 32'd0);
        checkOutput({name, "_rst_regs"}, regsOr(), 32'd0);
        rst = 1'b0;
    endtask

    logic [31:0] brTrace  [0:8] = '{32'd0, 32'd4, 32'd12, 32'd16, 32'd28, 32'd32, 32'd20, 32'd24, 32'd24};
    logic [31:0] nopTrace [0:8] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd20, 32'd24, 32'd28, 32'd36, 32'd36};

    initial begin
        // ---------------- ALU ----------------
        prog[0]  = encI(5, 0, 0, 1, 'h13);
        prog[1]  = encI(-3, 0, 0, 2, 'h13);
        prog[2]  = encR(0, 2, 1, 0, 3);
        prog[3]  = encR(32, 2, 1, 0, 4);
        prog[4]  = encR(0, 1, 2, 2, 5);
        prog[5]  = encR(0, 1, 2, 3, 6);
        prog[6]  = encR(32, 1, 2, 5, 7);
        prog[7]  = encR(0, 1, 2, 5, 8);
        prog[8]  = encI(-1, 2, 4, 9, 'h13);
        prog[9]  = encI(-1, 1, 3, 10, 'h13);
        prog[10] = encI(3, 1, 1, 11, 'h13);
        prog[11] = encI(15, 2, 7, 12, 'h13);
        prog[12] = encI(-2, 2, 2, 13, 'h13);
        prog[13] = encJ(0, 0);
        progLen  = 14;
        applyStimulus("alu");
        stepCycles(1);
        checkOutput("fetch_pc4", dut.pc_q, 32'd4);
        stepCycles(15);
        checkOutput("add_x3", dut.regs_q[3], 32'd2);
        checkOutput("sub_x4", dut.regs_q[4], 32'd8);
        checkOutput("slt_x5", dut.regs_q[5], 32'd1);
        checkOutput("sltu_x6", dut.regs_q[6], 32'd0);
        checkOutput("sra_x7", dut.regs_q[7], 32'hFFFFFFFF);
        checkOutput("srl_x8", dut.regs_q[8], 32'h07FFFFFF);
        checkOutput("xori_x9", dut.regs_q[9], 32'd2);
        checkOutput("sltiu_x10", dut.regs_q[10], 32'd1);
        checkOutput("slli_x11", dut.regs_q[11], 32'd40);
        checkOutput("andi_x12", dut.regs_q[12], 32'hD);
        checkOutput("slti_x13", dut.regs_q[13], 32'd1);
        checkOutput("alu_end_pc", dut.pc_q, 32'd52);

        // ---------------- load/store ----------------
        prog[0] = encI('h7F, 0, 0, 1, 'h13);
        prog[1] = encS(8, 1, 0);
        prog[2] = encI(8, 0, 2, 2, 'h03);
        prog[3] = encU('h12345, 3, 'h37);
        prog[4] = encU(0, 4, 'h17);
        prog[5] = encS(-4, 3, 1);
        prog[6] = encI(120, 0, 2, 5, 'h03);
        prog[7] = encJ(0, 0);
        progLen = 8;
        applyStimulus("ldst");
        stepCycles(10);
        checkOutput("sw_mem2", dut.datamem.memfile[2], 32'h7F);
        checkOutput("lw_x2", dut.regs_q[2], 32'h7F);
        checkOutput("lui_x3", dut.regs_q[3], 32'h12345000);
        checkOutput("auipc_x4", dut.regs_q[4], 32'd16);
        checkOutput("sw_unaligned_mem30", dut.datamem.memfile[30], 32'h12345000);
        checkOutput("lw_x5", dut.regs_q[5], 32'h12345000);

        // ---------------- branches / jumps ----------------
        prog[0] = encI(1, 0, 0, 1, 'h13);
        prog[1] = encB(8, 0, 0, 0);
        prog[2] = encI(7, 0, 0, 2, 'h13);
        prog[3] = encB(8, 0, 0, 1);
        prog[4] = encJ(12, 1);
        prog[5] = encI(3, 0, 0, 3, 'h13);
        prog[6] = encJ(0, 0);
        prog[7] = encI(4, 0, 0, 4, 'h13);
        prog[8] = encI(0, 1, 0, 0, 'h67);
        progLen = 9;
        applyStimulus("br");
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("br_pc%0d", k), dut.pc_q, brTrace[k]);
            @(negedge clk);
        end
        checkOutput("beq_skip_x2", dut.regs_q[2], 32'd0);
        checkOutput("jal_link_x1", dut.regs_q[1], 32'd20);
        checkOutput("ret_x3", dut.regs_q[3], 32'd3);
        checkOutput("target_x4", dut.regs_q[4], 32'd4);

        // ---------------- x0, illegal word, signed/unsigned branches ----------------
        dut.datamem.memfile[0] = 32'hDEADBEEF;
        prog[0] = encI(9, 0, 0, 0, 'h13);
        prog[1] = 32'h00000000;
        prog[2] = encI(-1, 0, 0, 1, 'h13);
        prog[3] = encB(8, 0, 1, 4);
        prog[4] = encI(1, 0, 0, 2, 'h13);
        prog[5] = encB(8, 0, 1, 6);
        prog[6] = encI(2, 0, 0, 3, 'h13);
        prog[7] = encB(8, 0, 1, 7);
        prog[8] = encI(5, 0, 0, 4, 'h13);
        prog[9] = encJ(0, 0);
        progLen = 10;
        applyStimulus("nop");
        for (int k = 0; k < 9; k++) begin
            checkOutput($sformatf("nop_pc%0d", k), dut.pc_q, nopTrace[k]);
            if (k == 2) checkOutput("nop_regs_unchanged", regsOr(), 32'd0);
            @(negedge clk);
        end
        checkOutput("x0_zero", dut.regs_q[0], 32'd0);
        checkOutput("blt_skip_x2", dut.regs_q[2], 32'd0);
        checkOutput("bltu_fall_x3", dut.regs_q[3], 32'd2);
        checkOutput("bgeu_skip_x4", dut.regs_q[4], 32'd0);
        checkOutput("nop_mem0", dut.datamem.memfile[0], 32'hDEADBEEF);

        // ---------------- reset mid-run ----------------
        prog[0] = encI(0, 0, 0, 1, 'h13);
        prog[1] = encI(1, 1, 0, 1, 'h13);
        prog[2] = encJ(-4, 0);
        progLen = 3;
        applyStimulus("loop");
        stepCycles(7);
        checkOutput("loop_pc_a", dut.pc_q, 32'd4);
        checkOutput("loop_x1_a", dut.regs_q[1], 32'd3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_pc", dut.pc_q, 32'd0);
        checkOutput("midrst_x1", dut.regs_q[1], 32'd0);
        rst = 1'b0;
        stepCycles(7);
        checkOutput("loop_pc_b", dut.pc_q, 32'd4);
        checkOutput("loop_x1_b", dut.regs_q[1], 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
